pattern_sweep_ctrl: RTL and testbench
=====================================

# pattern_sweep_ctrl

Sequencer that drives an exhaustive input sweep into a combinational or sequential benchmark under test (DUT) and captures its response. It steps a registered IN_W-bit pattern from 0 to 2^IN_W−1, waits a programmable settle time, and samples the DUT output. Each sample goes to a logging port through a valid/ready handshake and is folded into a rotate-XOR signature. The final signature is compared against a golden value to flag a trojan-altered response.

## Interface
- IN_W, 3, DUT input width; sweep covers 2^IN_W patterns
- OUT_W, 1, DUT output width (OUT_W ≤ SIG_W)
- SIG_W, 16, signature width
- SETTLE, 1, cycles to wait after a new pattern before sampling (≥1)

- CK  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin sweep; sampled only in IDLE
- abort  in  1  synchronous abort; return to IDLE without done
- pattern  out  IN_W  registered stimulus to DUT
- dut_out  in  OUT_W  DUT response
- cap_valid  out  1  capture record valid
- cap_ready  in  1  logger accepts record
- cap_pattern  out  IN_W  pattern of current record
- cap_data  out  OUT_W  sampled dut_out of current record
- golden_sig  in  SIG_W  expected final signature; sampled at DONE
- signature  out  SIG_W  running/final signature
- busy  out  1  high in SETTLE and CAPTURE
- done  out  1  one-cycle pulse at sweep completion
- mismatch  out  1  signature ≠ golden_sig at completion; sticky until next start

## Operation
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE, start=1: pattern←0, signature←0, mismatch←0, settle count←0, go to SETTLE. start in any other state is ignored.
- SETTLE: count cycles. On the SETTLE-th cycle's edge:
  - cap_data←dut_out and cap_pattern←pattern.
  - signature←{signature[SIG_W−2:0], signature[SIG_W−1]} XOR zero-extended dut_out.
  - Go to CAPTURE.
- CAPTURE: cap_valid=1, and cap_pattern/cap_data are held stable until cap_ready=1. On acceptance:
  - If pattern = 2^IN_W−1: go to DONE.
  - Else pattern←pattern+1, count←0, go to SETTLE.
- DONE: done=1 for exactly one cycle; mismatch←(signature ≠ golden_sig); go to IDLE.
- pattern, signature, cap_pattern and cap_data hold their last values in IDLE until the next accepted start.
- abort=1 in SETTLE/CAPTURE/DONE: go to IDLE next edge.
  - cap_valid, busy and done are 0 from that edge.
  - signature and pattern are frozen; mismatch is unchanged.
  - abort has priority over cap_ready and the settle count.
  - abort in IDLE has no effect.
- Pattern increment never wraps inside a sweep; the terminal pattern always exits to DONE.

## Timing
- Reset (reset=0, asynchronous): state IDLE; all outputs 0 (pattern, cap_*, signature, busy, done, mismatch).
- Deassertion takes effect at the next CK edge.
- Start accepted at edge E0: busy=1 and pattern=0 visible after E0.
- With cap_ready held high, each pattern takes SETTLE+1 cycles. done is high in cycle 1+2^IN_W·(SETTLE+1) after E0; for the defaults that is cycle 17.
- cap_valid rises the cycle after the sampling edge.
- Each cycle cap_ready is low adds exactly one cycle of stall. pattern holds during a stall, so the DUT input is stable.
- The cycle after done, the block is in IDLE. A start asserted in that cycle is accepted.
- busy is low in IDLE and DONE.

## Test plan
- Defaults, dut_out=0, cap_ready=1, golden_sig=0x0000 → 8 records with patterns 0..7 and data 0; signature 0x0000; done at cycle 17; mismatch=0.
- dut_out=1 constant, golden_sig=0x00FF → signature 0x00FF; mismatch=0. Repeat with golden_sig=0x00FE → mismatch=1, held until the next start.
- dut_out=pattern[0] → cap_data sequence 0,1,0,1,0,1,0,1; signature 0x0055.
- cap_ready low for 3 cycles at pattern 4 → cap_valid, cap_pattern=4 and pattern held stable throughout; done delayed by exactly 3 cycles; signature unchanged versus the no-stall run.
- abort during pattern 5 → IDLE next cycle; no done pulse; busy=0. A new start restarts from pattern 0 with signature cleared.
- reset asserted mid-sweep in CAPTURE → all outputs 0 immediately, without waiting for CK. start while busy → ignored; sweep timing unchanged.

Source files
------------

// File: rtl/pattern_sweep_ctrl.sv
// pattern_sweep_ctrl
//
// Drives an exhaustive input sweep into a benchmark circuit and captures its
// response. The registered pattern steps from 0 to 2^IN_W-1. After each new
// pattern the block waits SETTLE cycles, then samples dut_out. Each sample is
// offered to a logger over a valid/ready handshake and folded into a
// rotate-XOR signature. When the sweep completes, the final signature is
// compared against golden_sig, and a difference raises the sticky mismatch
// flag.
//
// Ports
//   CK          in   clock, rising edge
//   reset       in   asynchronous active-low reset
//   start       in   begin a sweep (honoured only in IDLE)
//   abort       in   synchronous abort back to IDLE, no done pulse
//   pattern     out  registered stimulus to the benchmark
//   dut_out     in   benchmark response
//   cap_valid   out  capture record valid
//   cap_ready   in   logger accepts the record
//   cap_pattern out  pattern of the current record
//   cap_data    out  sampled dut_out of the current record
//   golden_sig  in   expected final signature, sampled in DONE
//   signature   out  running/final signature
//   busy        out  high in SETTLE and CAPTURE
//   done        out  one-cycle completion pulse
//   mismatch    out  final signature differed from golden_sig (sticky)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; results of the last sweep are held
// SETTLE  | new pattern applied, counting down the settle time
// CAPTURE | record presented on cap_*, waiting for cap_ready
// DONE    | one-cycle completion; golden comparison updates mismatch

module pattern_sweep_ctrl #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 1,
    parameter int SIG_W  = 16,
    parameter int SETTLE = 1
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  pattern,
    input  logic [OUT_W-1:0] dut_out,
    output logic             cap_valid,
    input  logic             cap_ready,
    output logic [IN_W-1:0]  cap_pattern,
    output logic [OUT_W-1:0] cap_data,
    input  logic [SIG_W-1:0] golden_sig,
    output logic [SIG_W-1:0] signature,
    output logic             busy,
    output logic             done,
    output logic             mismatch
);

    // The settle timer counts down from SETTLE-1. Reaching zero marks the
    // SETTLE-th cycle in SETTLE, which is the cycle whose closing edge samples.
    localparam int              CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LD  = CNT_W'(SETTLE - 1);
    localparam logic [IN_W-1:0]  PAT_LAST = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] settle_cnt;

    logic do_start;
    logic do_count;
    logic do_sample;
    logic do_advance;
    logic do_compare;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // abort is tested first in every active state, so it overrides both the
    // settle terminal count and a pending cap_ready.
    always_comb begin
        state_nx   = state;
        do_start   = 1'b0;
        do_count   = 1'b0;
        do_sample  = 1'b0;
        do_advance = 1'b0;
        do_compare = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    do_start = 1'b1;
                    state_nx = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (settle_cnt == '0) begin
                    do_sample = 1'b1;
                    state_nx  = ST_CAPTURE;
                end else begin
                    do_count = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (cap_ready) begin
                    if (pattern == PAT_LAST) begin
                        state_nx = ST_DONE;
                    end else begin
                        do_advance = 1'b1;
                        state_nx   = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
                if (!abort) begin
                    do_compare = 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            pattern     <= '0;
            cap_pattern <= '0;
            cap_data    <= '0;
            signature   <= '0;
            mismatch    <= 1'b0;
            settle_cnt  <= '0;
        end else begin
            if (do_start) begin
                pattern    <= '0;
                signature  <= '0;
                mismatch   <= 1'b0;
                settle_cnt <= CNT_LD;
            end
            if (do_count) begin
                settle_cnt <= settle_cnt - 1'b1;
            end
            if (do_sample) begin
                cap_pattern <= pattern;
                cap_data    <= dut_out;
                signature   <= {signature[SIG_W-2:0], signature[SIG_W-1]}
                               ^ SIG_W'(dut_out);
            end
            if (do_advance) begin
                pattern    <= pattern + 1'b1;
                settle_cnt <= CNT_LD;
            end
            if (do_compare) begin
                mismatch <= (signature != golden_sig);
            end
        end
    end

    // Status outputs decode straight from the state register, so they clear
    // the instant reset asserts and drop on the edge that takes an abort.
    assign cap_valid = (state == ST_CAPTURE);
    assign busy      = (state == ST_SETTLE) || (state == ST_CAPTURE);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_pattern_sweep_ctrl.sv
module tb_pattern_sweep_ctrl;

    localparam int IN_W   = 3;
    localparam int OUT_W  = 1;
    localparam int SIG_W  = 16;
    localparam int SETTLE = 1;
    localparam int NPAT   = 1 << IN_W;

    logic             CK = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [IN_W-1:0]  pattern;
    logic [OUT_W-1:0] dut_out;
    logic             cap_valid;
    logic             cap_ready = 1'b1;
    logic [IN_W-1:0]  cap_pattern;
    logic [OUT_W-1:0] cap_data;
    logic [SIG_W-1:0] golden_sig = '0;
    logic [SIG_W-1:0] signature;
    logic             busy;
    logic             done;
    logic             mismatch;

    pattern_sweep_ctrl #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SIG_W(SIG_W), .SETTLE(SETTLE)
    ) dut (
        .CK(CK), .reset(reset), .start(start), .abort(abort),
        .pattern(pattern), .dut_out(dut_out),
        .cap_valid(cap_valid), .cap_ready(cap_ready),
        .cap_pattern(cap_pattern), .cap_data(cap_data),
        .golden_sig(golden_sig), .signature(signature),
        .busy(busy), .done(done), .mismatch(mismatch)
    );

    always #5 CK = ~CK;

    int cyc = 0;
    always @(posedge CK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Benchmark circuit emulation: 0 constant, 1 constant, pattern LSB, random table
    int               mode = 0;
    logic [OUT_W-1:0] tbl [NPAT];
    always_comb begin
        dut_out = '0;
        case (mode)
            1:       dut_out = 1'b1;
            2:       dut_out = pattern[0];
            3:       dut_out = tbl[pattern];
            default: dut_out = '0;
        endcase
    end

    function automatic logic [OUT_W-1:0] model_out(input int m, input int p);
        if (m == 1) return 1'b1;
        if (m == 2) return OUT_W'(p % 2);
        if (m == 3) return tbl[p];
        return '0;
    endfunction

    function automatic logic [SIG_W-1:0] model_sig(input int m, input int npat);
        logic [SIG_W-1:0] s = '0;
        for (int p = 0; p < npat; p++) begin
            s = ((s << 1) | (s >> (SIG_W - 1))) ^ SIG_W'(model_out(m, p));
        end
        return s;
    endfunction

    typedef struct {
        logic [IN_W-1:0]  p;
        logic [OUT_W-1:0] d;
    } rec_t;
    rec_t exp_q[$];
    int   stall_cnt = 0;

    // Monitor: every cycle a record is presented it must match the queue head
    // (so it is also stable through stalls); it is popped on acceptance.
    initial forever begin
        @(negedge CK);
        if (reset && cap_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record: got pattern %0d with empty queue", cap_pattern);
            end else begin
                chk("cap_pattern", 32'(cap_pattern), 32'(exp_q[0].p));
                chk("cap_data", 32'(cap_data), 32'(exp_q[0].d));
                chk("pattern_stable", 32'(pattern), 32'(exp_q[0].p));
                if (cap_ready) void'(exp_q.pop_front());
                else stall_cnt++;
            end
        end
    end

    int stall_pat  = -1;
    int stall_left = 0;
    bit rand_ready = 1'b0;
    initial forever begin
        @(posedge CK);
        #1;
        if (rand_ready) begin
            cap_ready = ($urandom_range(0, 2) != 0);
        end else if (cap_valid && stall_left > 0 && int'(cap_pattern) == stall_pat) begin
            cap_ready = 1'b0;
            stall_left--;
        end else begin
            cap_ready = 1'b1;
        end
    end

    task automatic fill_queue(input int m);
        rec_t r;
        exp_q.delete();
        for (int p = 0; p < NPAT; p++) begin
            r.p = IN_W'(p);
            r.d = model_out(m, p);
            exp_q.push_back(r);
        end
    endtask

    task automatic do_start(output int e0);
        @(negedge CK);
        start = 1'b1;
        @(posedge CK);
        #1;
        e0 = cyc;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("pattern_after_start", 32'(pattern), 32'd0);
        chk("sig_after_start", 32'(signature), 32'd0);
        chk("mismatch_after_start", 32'(mismatch), 32'd0);
    endtask

    task automatic run_sweep(input int m, input logic [SIG_W-1:0] gold, input bit gold_model,
                             input int spat, input int sn, input bit rr, input bit poke);
        int e0;
        int dcyc = 0;
        bit seen = 1'b0;
        logic [SIG_W-1:0] sig;
        bit exp_mm;
        mode = m;
        sig = model_sig(m, NPAT);
        golden_sig = gold_model ? sig : gold;
        exp_mm = (sig != golden_sig);
        fill_queue(m);
        stall_pat = spat;
        stall_left = sn;
        rand_ready = rr;
        stall_cnt = 0;
        do_start(e0);
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge CK);
            start = poke && (cyc - e0 == 6);
            if (done) begin
                seen = 1'b1;
                dcyc = cyc - e0 + 1;
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("done_cycle", 32'(dcyc), 32'(1 + NPAT * (SETTLE + 1) + (rr ? stall_cnt : sn)));
        chk("busy_in_done", 32'(busy), 32'd0);
        chk("signature_final", 32'(signature), 32'(sig));
        @(negedge CK);
        rand_ready = 1'b0;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("mismatch", 32'(mismatch), 32'(exp_mm));
        chk("records_left", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge CK);
        chk("mismatch_held", 32'(mismatch), 32'(exp_mm));
        chk("pattern_held", 32'(pattern), 32'(NPAT - 1));
        chk("signature_held", 32'(signature), 32'(sig));
    endtask

    task automatic run_abort(input int m);
        int e0;
        int ndone = 0;
        bit found = 1'b0;
        logic mm_before;
        mode = m;
        fill_queue(m);
        stall_pat = -1;
        stall_left = 0;
        do_start(e0);
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge CK);
            if (pattern == IN_W'(5)) found = 1'b1;
        end
        chk("abort_reached_p5", 32'(found), 32'd1);
        mm_before = mismatch;
        abort = 1'b1;
        @(posedge CK);
        #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(cap_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pattern", 32'(pattern), 32'd5);
        chk("abort_signature", 32'(signature), 32'(model_sig(m, 5)));
        chk("abort_mismatch", 32'(mismatch), 32'(mm_before));
        for (int k = 0; k < 8; k++) begin
            @(negedge CK);
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pattern"}, 32'(pattern), 32'd0);
        chk({tag, "_cap_pattern"}, 32'(cap_pattern), 32'd0);
        chk({tag, "_cap_data"}, 32'(cap_data), 32'd0);
        chk({tag, "_signature"}, 32'(signature), 32'd0);
        chk({tag, "_cap_valid"}, 32'(cap_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_mismatch"}, 32'(mismatch), 32'd0);
    endtask

    task automatic run_reset_mid();
        int e0;
        bit found = 1'b0;
        mode = 1;
        fill_queue(1);
        stall_pat = -1;
        stall_left = 0;
        do_start(e0);
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge CK);
            if (cap_valid && pattern == IN_W'(3)) found = 1'b1;
        end
        chk("reset_reached_capture", 32'(found), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        @(negedge CK);
        reset = 1'b1;
        @(negedge CK);
        chk("reset_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #3;
        check_all_zero("reset");
        @(negedge CK);
        reset = 1'b1;
        repeat (2) @(negedge CK);
        check_all_zero("post_reset_idle");

        run_sweep(0, 16'h0000, 1'b0, -1, 0, 1'b0, 1'b0);
        run_sweep(1, 16'h00FF, 1'b0, -1, 0, 1'b0, 1'b0);
        run_sweep(1, 16'h00FE, 1'b0, -1, 0, 1'b0, 1'b0);
        run_sweep(2, 16'h0055, 1'b0, -1, 0, 1'b0, 1'b1);
        run_sweep(2, 16'h0055, 1'b0, 4, 3, 1'b0, 1'b0);
        run_abort(1);
        run_sweep(1, 16'h00FF, 1'b0, -1, 0, 1'b0, 1'b0);
        run_reset_mid();
        for (int it = 0; it < 4; it++) begin
            for (int p = 0; p < NPAT; p++) tbl[p] = OUT_W'($urandom_range(0, 1));
            run_sweep(3, SIG_W'($urandom), (it % 2) == 0, -1, 0, 1'b1, (it == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
